// File: rtl/cla_seq_pkg.sv
// Shared definitions for the nibble-serial CLA add/subtract sequencer.
//   NIB_W     : width of one slice operand (one nibble)
//   state_e   : sequencer FSM states
//   nib_count : number of nibbles needed to cover an operand of a given width
package cla_seq_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_e;

  function automatic int unsigned nib_count(input int unsigned width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/cla_nibble_sequencer.sv
// Multi-cycle WIDTH-bit add/subtract built on one shared, pipelined 4-bit CLA slice.
// Operands are fed to the slice one nibble at a time, LSB first, with the slice carry-out
// chained into the next nibble's carry-in. The assembled result is returned over a
// valid/ready response port.
//
// Ports:
//   clk, reset                      clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready             request handshake
//   req_a, req_b, req_cin, req_sub  operands, carry-in (add only), 1 = A - B
//   rsp_valid/rsp_ready             response handshake
//   rsp_sum, rsp_cout, rsp_ovf      result, MSB carry-out (1 = no borrow), signed overflow
//   cla_a, cla_b, cla_cin           operands driven to the external slice
//   cla_s, cla_cout                 slice results, valid CLA_LAT edges after operands
module cla_nibble_sequencer
  import cla_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned CLA_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_cin,
  input  logic             req_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic [3:0]       cla_a,
  output logic [3:0]       cla_b,
  output logic             cla_cin,
  input  logic [3:0]       cla_s,
  input  logic             cla_cout
);

  localparam int unsigned NumNib = nib_count(WIDTH);
  localparam int unsigned IdxW   = (NumNib > 1) ? $clog2(NumNib) : 1;
  localparam int unsigned LatW   = (CLA_LAT > 1) ? $clog2(CLA_LAT) : 1;

  localparam logic [IdxW-1:0] IdxLast = IdxW'(NumNib - 1);
  localparam logic [LatW-1:0] LatLast = LatW'(CLA_LAT - 1);

  if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W || CLA_LAT < 1) begin : g_param_check
    $error("cla_nibble_sequencer: WIDTH must be a multiple of 4 (>= 4) and CLA_LAT >= 1");
  end

  state_e           r_state;
  logic [WIDTH-1:0] r_a;        // remaining (not yet issued) nibbles of A
  logic [WIDTH-1:0] r_b;        // remaining nibbles of B_eff
  logic [WIDTH-1:0] r_acc;      // sum nibbles shift in from the top, LSB nibble first
  logic             r_a_msb;
  logic             r_b_msb;
  logic [IdxW-1:0]  r_idx;
  logic [LatW-1:0]  r_lat;

  logic             r_req_ready;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_sum;
  logic             r_rsp_cout;
  logic             r_rsp_ovf;
  logic [3:0]       r_cla_a;
  logic [3:0]       r_cla_b;
  logic             r_cla_cin;

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_ovf;

  always_comb begin
    w_b_eff    = req_sub ? ~req_b : req_b;
    // After NumNib captures the first-captured nibble has shifted down to bit 0.
    w_acc_next = (r_acc >> NIB_W) | (WIDTH'(cla_s) << (WIDTH - NIB_W));
    w_ovf      = (r_a_msb == r_b_msb) && (w_acc_next[WIDTH-1] != r_a_msb);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_a_msb     <= 1'b0;
      r_b_msb     <= 1'b0;
      r_idx       <= '0;
      r_lat       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_sum   <= '0;
      r_rsp_cout  <= 1'b0;
      r_rsp_ovf   <= 1'b0;
      r_cla_a     <= '0;
      r_cla_b     <= '0;
      r_cla_cin   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (req_valid && r_req_ready) begin
            // Nibble 0 is presented to the slice straight from the request.
            r_cla_a     <= req_a[NIB_W-1:0];
            r_cla_b     <= w_b_eff[NIB_W-1:0];
            r_cla_cin   <= req_sub ? 1'b1 : req_cin;
            r_a         <= req_a >> NIB_W;
            r_b         <= w_b_eff >> NIB_W;
            r_a_msb     <= req_a[WIDTH-1];
            r_b_msb     <= w_b_eff[WIDTH-1];
            r_idx       <= '0;
            r_lat       <= '0;
            r_req_ready <= 1'b0;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          r_lat   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (r_lat == LatLast) begin
            r_acc <= w_acc_next;
            if (r_idx == IdxLast) begin
              r_rsp_valid <= 1'b1;
              r_rsp_sum   <= w_acc_next;
              r_rsp_cout  <= cla_cout;
              r_rsp_ovf   <= w_ovf;
              r_cla_a     <= '0;
              r_cla_b     <= '0;
              r_cla_cin   <= 1'b0;
              r_state     <= DONE;
            end else begin
              r_idx     <= r_idx + IdxW'(1);
              r_cla_a   <= r_a[NIB_W-1:0];
              r_cla_b   <= r_b[NIB_W-1:0];
              r_cla_cin <= cla_cout;
              r_a       <= r_a >> NIB_W;
              r_b       <= r_b >> NIB_W;
              r_state   <= ISSUE;
            end
          end else begin
            r_lat <= r_lat + LatW'(1);
          end
        end
        DONE: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_cout  = r_rsp_cout;
  assign rsp_ovf   = r_rsp_ovf;
  assign cla_a     = r_cla_a;
  assign cla_b     = r_cla_b;
  assign cla_cin   = r_cla_cin;

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Bench for cla_nibble_sequencer (WIDTH=16, CLA_LAT=1) with a behavioural one-cycle
// 4-bit adder slice standing in for the external CLA4CLKd.
module tb_cla_nibble_sequencer;

  localparam int unsigned W = 16;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         req_cin;
  logic         req_sub;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout;
  logic         rsp_ovf;
  logic [3:0]   cla_a;
  logic [3:0]   cla_b;
  logic         cla_cin;
  logic [3:0]   cla_s;
  logic         cla_cout;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  exp_t q[$];

  cla_nibble_sequencer #(
    .WIDTH  (W),
    .CLA_LAT(1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_cin  (req_cin),
    .req_sub  (req_sub),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_sum  (rsp_sum),
    .rsp_cout (rsp_cout),
    .rsp_ovf  (rsp_ovf),
    .cla_a    (cla_a),
    .cla_b    (cla_b),
    .cla_cin  (cla_cin),
    .cla_s    (cla_s),
    .cla_cout (cla_cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Slice stand-in: one register stage, active-low reset shared with the sequencer.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      {cla_cout, cla_s} <= 5'd0;
    end else begin
      {cla_cout, cla_s} <= {1'b0, cla_a} + {1'b0, cla_b} + {4'd0, cla_cin};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_sum"},   32'(rsp_sum),   32'd0);
    check({tag, "_rsp_cout"},  32'(rsp_cout),  32'd0);
    check({tag, "_rsp_ovf"},   32'(rsp_ovf),   32'd0);
    check({tag, "_cla_a"},     32'(cla_a),     32'd0);
    check({tag, "_cla_b"},     32'(cla_b),     32'd0);
    check({tag, "_cla_cin"},   32'(cla_cin),   32'd0);
  endtask

  // Present one request for a single accept cycle; optionally push its expected response.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, input bit push, input logic [W-1:0] e_sum,
                       input logic e_cout, input logic e_ovf);
    exp_t e;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) break;
      step();
    end
    check("req_ready_timeout", 32'(req_ready), 32'd1);
    req_a     = a;
    req_b     = b;
    req_cin   = cin;
    req_sub   = sub;
    req_valid = 1'b1;
    acc_cyc   = cyc;
    if (push) begin
      e.sum  = e_sum;
      e.cout = e_cout;
      e.ovf  = e_ovf;
      q.push_back(e);
    end
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) break;
      step();
    end
    check("rsp_timeout", 32'(rsp_valid), 32'd1);
  endtask

  // Monitor: compare against the scoreboard whenever a new response appears.
  initial begin
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rsp_valid && !prev_v) begin
        if (q.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_sum), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          check("rsp_sum",     32'(rsp_sum),       32'(e.sum));
          check("rsp_cout",    32'(rsp_cout),      32'(e.cout));
          check("rsp_ovf",     32'(rsp_ovf),       32'(e.ovf));
          check("rsp_latency", 32'(cyc - acc_cyc), 32'd9);
        end
      end
      prev_v = rsp_valid;
    end
  end

  initial begin
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = 1'b0;
    req_sub   = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) step();
    check_reset_vals("por");
    reset = 1'b1;
    step();

    // Plain add.
    issue(16'h1234, 16'h0FCD, 1'b0, 1'b0, 1'b1, 16'h2201, 1'b0, 1'b0);
    wait_rsp();
    step();

    // Full carry ripple: nibble 0 in cycle 1, then carry-in 1 on nibbles 1..3.
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    check("nib0_cla_a",   32'(cla_a),   32'hF);
    check("nib0_cla_b",   32'(cla_b),   32'h1);
    check("nib0_cla_cin", 32'(cla_cin), 32'h0);
    for (int n = 1; n < 4; n++) begin
      step();
      step();
      check($sformatf("nib%0d_cla_cin", n), 32'(cla_cin), 32'h1);
      check($sformatf("nib%0d_cla_b", n),   32'(cla_b),   32'h0);
    end
    wait_rsp();
    step();

    // Subtraction: borrow, then signed overflow without borrow.
    issue(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    check("sub_nib0_cla_b",   32'(cla_b),   32'h8);
    check("sub_nib0_cla_cin", 32'(cla_cin), 32'h1);
    wait_rsp();
    step();
    issue(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    wait_rsp();
    step();

    // Positive overflow held under backpressure; a request pulse meanwhile is ignored.
    rsp_ready = 1'b0;
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
    wait_rsp();
    for (int k = 0; k < 5; k++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_sum",   32'(rsp_sum),   32'h8000);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_cla_a",     32'(cla_a),     32'd0);
      if (k == 2) begin
        req_a     = 16'h1111;
        req_b     = 16'h2222;
        req_valid = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      step();
    end
    req_valid = 1'b0;
    check("bp_rsp_ovf_held", 32'(rsp_ovf), 32'd1);
    rsp_ready = 1'b1;
    step();
    check("bp_release_valid", 32'(rsp_valid), 32'd0);
    check("bp_release_ready", 32'(req_ready), 32'd1);

    // Reset in the ISSUE cycle of nibble 2; this operation must produce no response.
    issue(16'hABCD, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    repeat (4) step();
    check("mid_nib2_cla_a", 32'(cla_a), 32'hB);
    reset = 1'b0;
    #1;
    check_reset_vals("midrst");
    step();
    step();
    reset = 1'b1;
    step();
    issue(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0);
    wait_rsp();
    step();
    repeat (3) step();
    check("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
